// File: rtl/call_stack_pkg.sv
// Shared constants, opcode decode type and offset sign-extension for the call_stack unit.
// The optional CALL_STACK_PROTECT_EN macro is consumed by call_stack.sv.
package call_stack_pkg;

  localparam int unsigned DEFAULT_PC_W  = 11;
  localparam int unsigned DEFAULT_OFS_W = 10;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_CALL,
    OP_RET
  } op_e;

  // Sign-extends the low ofs_w bits of ofs to 32 bits; callers truncate to their PC width.
  function automatic logic [31:0] sext_ofs(input logic [31:0] ofs, input int unsigned ofs_w);
    logic [31:0] shifted;
    shifted  = ofs << (32 - ofs_w);
    sext_ofs = 32'($signed(shifted) >>> (32 - ofs_w));
  endfunction

endpackage

// File: rtl/call_stack_mem.sv
// DEPTH x PC_W return-address register file with a circular write pointer.
// Read port always presents the most recent entry (wp-1); a pop clears that entry.
module call_stack_mem
  import call_stack_pkg::*;
#(
  parameter int unsigned PC_W  = DEFAULT_PC_W,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] wdata,
  output logic [PC_W-1:0] rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [PC_W-1:0] entry [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   top_idx;

  assign top_idx = wp - AW'(1);
  assign rdata   = entry[top_idx];

  // When full, wp already points at the oldest entry, so a push overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry[i] <= '0;
      end
    end else if (push) begin
      entry[wp] <= wdata;
      wp        <= wp + AW'(1);
    end else if (pop) begin
      entry[top_idx] <= '0;
      wp             <= top_idx;
    end
  end

endmodule

// File: rtl/call_stack.sv
// Return-address stack: call pushes pc_in and redirects to pc_in+offset, ret pops and redirects
// to popped PC + 1. Define CALL_STACK_PROTECT_EN to reject calls while full instead of overwriting.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int unsigned PC_W  = DEFAULT_PC_W,
  parameter int unsigned OFS_W = DEFAULT_OFS_W,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       call,
  input  logic                       ret,
  input  logic [OFS_W-1:0]           offset,
  input  logic [PC_W-1:0]            pc_in,
  output logic [PC_W-1:0]            pc_out,
  output logic                       pc_valid,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned LW = $clog2(DEPTH + 1);

  op_e             op;
  logic            call_ok;
  logic            push;
  logic            pop;
  logic [PC_W-1:0] ofs_ext;
  logic [PC_W-1:0] top_pc;

  // Call has priority; a simultaneous ret is dropped entirely.
  always_comb begin
    op = OP_NONE;
    if (en) begin
      if (call) begin
        op = OP_CALL;
      end else if (ret) begin
        op = OP_RET;
      end
    end
  end

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign ofs_ext = PC_W'(sext_ofs(32'(offset), OFS_W));

`ifdef CALL_STACK_PROTECT_EN
  assign call_ok = !full;
`else
  assign call_ok = 1'b1;
`endif

  assign push = (op == OP_CALL) && call_ok;
  assign pop  = (op == OP_RET) && !empty;

  call_stack_mem #(
    .PC_W (PC_W),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(pc_in),
    .rdata(top_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out    <= '0;
      pc_valid  <= 1'b0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pc_valid <= push || pop;
      if (push) begin
        pc_out <= pc_in + ofs_ext;
        if (!full) begin
          level <= level + LW'(1);
        end
      end else if (pop) begin
        pc_out <= top_pc + PC_W'(1);
        level  <= level - LW'(1);
      end
      if ((op == OP_CALL) && full) begin
        overflow <= 1'b1;
      end
      if ((op == OP_RET) && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed scenarios plus random ops against a queue model.
// Honours CALL_STACK_PROTECT_EN to match the DUT build.
module tb_call_stack;

  localparam int PC_W  = 11;
  localparam int OFS_W = 10;
  localparam int DEPTH = 4;
  localparam int PC_MOD = 1 << PC_W;
`ifdef CALL_STACK_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, en, call, ret;
  logic [OFS_W-1:0] offset;
  logic [PC_W-1:0]  pc_in;
  logic [PC_W-1:0]  pc_out;
  logic             pc_valid;
  logic [2:0]       level;
  logic             full, empty, overflow, underflow;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int q[$];
  int m_pc;
  bit m_valid, m_ovf, m_unf;

  always #5 clk = ~clk;

  call_stack dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .call     (call),
    .ret      (ret),
    .offset   (offset),
    .pc_in    (pc_in),
    .pc_out   (pc_out),
    .pc_valid (pc_valid),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .underflow(underflow)
  );

  function automatic int sext(input int o);
    return (o >= (1 << (OFS_W - 1))) ? o - (1 << OFS_W) : o;
  endfunction

  function automatic int wrap_pc(input int v);
    return ((v % PC_MOD) + PC_MOD) % PC_MOD;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":pc_out"}, int'(pc_out), m_pc);
    chk({tag, ":pc_valid"}, int'(pc_valid), int'(m_valid));
    chk({tag, ":level"}, int'(level), q.size());
    chk({tag, ":full"}, int'(full), int'(q.size() == DEPTH));
    chk({tag, ":empty"}, int'(empty), int'(q.size() == 0));
    chk({tag, ":overflow"}, int'(overflow), int'(m_ovf));
    chk({tag, ":underflow"}, int'(underflow), int'(m_unf));
  endtask

  task automatic model_op(input bit e, input bit c, input bit r, input int o, input int p);
    m_valid = 1'b0;
    if (e && c) begin
      if (q.size() == DEPTH) m_ovf = 1'b1;
      if (!(q.size() == DEPTH && PROT)) begin
        if (q.size() == DEPTH) void'(q.pop_front());
        q.push_back(p);
        m_pc    = wrap_pc(p + sext(o));
        m_valid = 1'b1;
      end
    end else if (e && r) begin
      if (q.size() == 0) begin
        m_unf = 1'b1;
      end else begin
        m_pc    = wrap_pc(q.pop_back() + 1);
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic step(input string tag, input bit e, input bit c, input bit r,
                      input int o, input int p);
    @(negedge clk);
    rst    = 1'b0;
    en     = e;
    call   = c;
    ret    = r;
    offset = OFS_W'(o);
    pc_in  = PC_W'(p);
    @(posedge clk);
    model_op(e, c, r, o, p);
    #1;
    check_all(tag);
  endtask

  // Reset asserted together with a call: reset must win.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst  = 1'b1;
    en   = 1'b1;
    call = 1'b1;
    ret  = 1'b0;
    pc_in  = PC_W'($urandom);
    offset = OFS_W'($urandom);
    @(posedge clk);
    q.delete();
    m_pc = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; call = 1'b0; ret = 1'b0; offset = '0; pc_in = '0;
    do_reset("rst0");

    // Test 1: reset after random ops
    for (int i = 0; i < 8; i++) step("pre_rst", 1'b1, 1'($urandom), 1'($urandom),
                                     int'($urandom_range(0, 1023)), int'($urandom_range(0, 2047)));
    do_reset("rst1");

    // Test 2: call then ret
    step("t2_call", 1, 1, 0, 'h005, 'h010);
    chk("t2_call_lit", int'(pc_out), 'h015);
    step("t2_ret", 1, 0, 1, 0, 'h015);
    chk("t2_ret_lit", int'(pc_out), 'h011);

    // Test 3: negative offset and PC wrap
    step("t3_neg", 1, 1, 0, 'h3FE, 'h100);
    chk("t3_neg_lit", int'(pc_out), 'h0FE);
    step("t3_wrap", 1, 1, 0, 'h001, 'h7FF);
    chk("t3_wrap_lit", int'(pc_out), 'h000);
    do_reset("rst3");

    // Test 4: overflow past DEPTH, then unwind
    for (int i = 1; i <= 5; i++) step("t4_call", 1, 1, 0, 0, i);
    for (int i = 0; i < 4; i++) step("t4_ret", 1, 0, 1, 0, 0);
    chk("t4_ovf_lit", int'(overflow), 1);

    // Test 5: ret on empty, later call still works
    step("t5_unf", 1, 0, 1, 0, 0);
    chk("t5_unf_lit", int'(underflow), 1);
    step("t5_call", 1, 1, 0, 'h002, 'h020);
    chk("t5_call_lit", int'(pc_out), 'h022);
    do_reset("rst5");

    // Test 6: call+ret together pushes only; en=0 holds state
    step("t6_c1", 1, 1, 0, 1, 'h040);
    step("t6_c2", 1, 1, 0, 1, 'h050);
    step("t6_both", 1, 1, 1, 1, 'h060);
    chk("t6_level_lit", int'(level), 3);
    step("t6_en0", 0, 1, 0, 1, 'h070);
    step("t6_idle", 1, 0, 0, 1, 'h070);

    // Random mix with occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd", $urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 1023)), int'($urandom_range(0, 2047)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
